// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared FSM states, opcode/func constants, ALU codes and mux encodings
package multicycle_control_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
        WB_R, WB_I, WB_MEM, BRANCH, JUMP, TRAP
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_SLTI = 6'b001010;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100, F_OR = 6'b100101, F_SLT = 6'b101010;
    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_INV = 4'b1111;
    localparam logic [1:0] BSRC_RT = 2'b00, BSRC_4 = 2'b01, BSRC_IMM = 2'b10, BSRC_IMM_SH = 2'b11;
    localparam logic [1:0] PC_ALU = 2'b00, PC_TARGET = 2'b01, PC_JUMP = 2'b10;
    localparam logic [1:0] CAUSE_NONE = 2'b00, CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10;
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       regwrite;
        logic       regdst;
        logic       mem2reg;
        logic       extop;
        logic       alusrc_a;
        logic [1:0] alusrc_b;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctl_t;
endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// alu_op_decode: maps R-type func or I-type opcode to a zero-extended aluop
// Ports: use_func selects func decode (R-type) over opcode decode (immediate);
//        aluop is ALU_INV (zero-extended) for unknown codes; legal flags a known code.
module alu_op_decode
    import multicycle_control_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic               use_func,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    output logic [ALUOP_W-1:0] aluop,
    output logic               legal
);
    logic [3:0] code;
    always_comb begin
        code = use_func ?
            (func == F_ADD ? ALU_ADD : func == F_SUB ? ALU_SUB : func == F_AND ? ALU_AND :
             func == F_OR ? ALU_OR : func == F_SLT ? ALU_SLT : ALU_INV) :
            (opcode == OP_ADDI ? ALU_ADD : opcode == OP_ANDI ? ALU_AND :
             opcode == OP_ORI ? ALU_OR : opcode == OP_SLTI ? ALU_SLT : ALU_INV);
    end
    assign legal = code != ALU_INV;
    assign aluop = ALUOP_W'(code);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS-style control FSM with memory timeout and sticky trap
// Ports: clk/rst_n (async active-low); opcode/func from IR; zero ALU flag; mem_ready handshake;
//        datapath strobes/selects, aluop, instr_done retire pulse, trap/trap_cause error status.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int TIMEOUT = 15,
    parameter int EN_IMM  = 1,
    parameter int EN_BNE  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               regwrite,
    output logic               regdst,
    output logic               mem2reg,
    output logic               extop,
    output logic               alusrc_a,
    output logic [1:0]         alusrc_b,
    output logic [1:0]         pc_src,
    output logic [ALUOP_W-1:0] aluop,
    output logic               instr_done,
    output logic               trap,
    output logic [1:0]         trap_cause
);
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [ALUOP_W-1:0] ADD_W = ALUOP_W'(ALU_ADD);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] cause_q, cause_d;
    ctl_t ctl;
    logic [ALUOP_W-1:0] aluop_sel, dec_aluop;
    logic dec_legal, imm_op, timeout;

    alu_op_decode #(.ALUOP_W(ALUOP_W)) u_dec (
        .use_func(state_q == EXEC_R),
        .opcode  (opcode),
        .func    (func),
        .aluop   (dec_aluop),
        .legal   (dec_legal)
    );

    assign imm_op = opcode == OP_ADDI || opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_SLTI;
    // The cycle whose increment would reach TIMEOUT is the last wait allowed; ready in that cycle still wins.
    assign timeout = !mem_ready && (int'(cnt_q) + 1 == TIMEOUT);

    always_comb begin
        ctl = '0;
        aluop_sel = '0;
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            FETCH: begin
                ctl.mem_read = 1'b1;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    ctl.alusrc_b = BSRC_4;
                    aluop_sel = ADD_W;
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                ctl.alusrc_b = BSRC_IMM_SH;
                ctl.extop = 1'b1;
                aluop_sel = ADD_W;
                if (opcode == OP_RTYPE) state_d = EXEC_R;
                else if (opcode == OP_LW || opcode == OP_SW) state_d = MEM_ADDR;
                else if (opcode == OP_BEQ || (EN_BNE != 0 && opcode == OP_BNE)) state_d = BRANCH;
                else if (opcode == OP_J) state_d = JUMP;
                else if (EN_IMM != 0 && imm_op) state_d = EXEC_I;
                else begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            EXEC_R: begin
                ctl.alusrc_a = 1'b1;
                aluop_sel = dec_aluop;
                state_d = dec_legal ? WB_R : TRAP;
                cause_d = dec_legal ? cause_q : CAUSE_ILLEGAL;
            end
            EXEC_I: begin
                ctl.alusrc_a = 1'b1;
                ctl.alusrc_b = BSRC_IMM;
                ctl.extop = opcode == OP_ADDI || opcode == OP_SLTI;
                aluop_sel = dec_aluop;
                state_d = WB_I;
            end
            MEM_ADDR: begin
                ctl.alusrc_a = 1'b1;
                ctl.alusrc_b = BSRC_IMM;
                ctl.extop = 1'b1;
                aluop_sel = ADD_W;
                state_d = opcode == OP_LW ? MEM_RD : MEM_WR;
            end
            MEM_RD, MEM_WR: begin
                ctl.iord = 1'b1;
                ctl.mem_read = state_q == MEM_RD;
                ctl.mem_write = state_q == MEM_WR;
                if (mem_ready) begin
                    ctl.instr_done = state_q == MEM_WR;
                    state_d = state_q == MEM_RD ? WB_MEM : FETCH;
                end else if (timeout) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            WB_R, WB_I, WB_MEM: begin
                ctl.regwrite = 1'b1;
                ctl.regdst = state_q == WB_R;
                ctl.mem2reg = state_q == WB_MEM;
                ctl.instr_done = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                ctl.alusrc_a = 1'b1;
                ctl.pc_src = PC_TARGET;
                ctl.pc_write = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
                ctl.instr_done = 1'b1;
                aluop_sel = ALUOP_W'(ALU_SUB);
                state_d = FETCH;
            end
            JUMP: begin
                ctl.pc_write = 1'b1;
                ctl.pc_src = PC_JUMP;
                ctl.instr_done = 1'b1;
                state_d = FETCH;
            end
            default: ;
        endcase
        cnt_d = state_d != state_q ? '0 :
                (state_q inside {FETCH, MEM_RD, MEM_WR}) && !mem_ready ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cnt_q <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Outputs are gated by rst_n so every strobe drops the instant reset asserts.
    assign {pc_write, ir_write, iord, mem_read, mem_write, regwrite, regdst, mem2reg,
            extop, alusrc_a, alusrc_b, pc_src, instr_done} = rst_n ? ctl : '0;
    assign aluop = rst_n ? aluop_sel : '0;
    assign trap = rst_n && state_q == TRAP;
    assign trap_cause = rst_n ? cause_q : CAUSE_NONE;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control
module tb_multicycle_control;
    logic clk = 1'b0, rst_n, zero, mem_ready;
    logic [5:0] opcode, func;
    logic pc_write, ir_write, iord, mem_read, mem_write, regwrite, regdst, mem2reg, extop, alusrc_a;
    logic [1:0] alusrc_b, pc_src, trap_cause;
    logic [3:0] aluop;
    logic instr_done, trap;
    int checks = 0, failures = 0, wr_seen = 0;
    logic mon = 1'b0;

    multicycle_control #(.ALUOP_W(4), .TIMEOUT(4), .EN_IMM(1), .EN_BNE(1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .regwrite(regwrite), .regdst(regdst), .mem2reg(mem2reg),
        .extop(extop), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .pc_src(pc_src),
        .aluop(aluop), .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mon && (regwrite || mem_write)) wr_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
        tick();
        chk("rst_mem_read", mem_read, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_trap", trap, 0);
        chk("rst_cause", trap_cause, 0);
        rst_n = 1'b1;
        // R-type ADD: FETCH-DECODE-EXEC_R-WB_R
        opcode = 6'b000000; func = 6'b100000; mem_ready = 1'b1;
        #1;
        chk("radd_f_irw", ir_write, 1);
        chk("radd_f_pcw", pc_write, 1);
        chk("radd_f_bsrc", alusrc_b, 2'b01);
        chk("radd_f_aluop", aluop, 4'b0010);
        tick();
        chk("radd_d_bsrc", alusrc_b, 2'b11);
        chk("radd_d_extop", extop, 1);
        tick();
        chk("radd_x_aluop", aluop, 4'b0010);
        chk("radd_x_srca", alusrc_a, 1);
        chk("radd_x_regw", regwrite, 0);
        tick();
        chk("radd_wb_regw", regwrite, 1);
        chk("radd_wb_regdst", regdst, 1);
        chk("radd_wb_done", instr_done, 1);
        tick();
        chk("radd_next_fetch", mem_read, 1);
        chk("radd_next_done", instr_done, 0);
        // LW with 3 wait cycles in MEM_RD, ready on the boundary cycle
        opcode = 6'b100011;
        #1;
        chk("lw_f_irw", ir_write, 1);
        tick();
        tick();
        chk("lw_ma_bsrc", alusrc_b, 2'b10);
        mem_ready = 1'b0;
        tick();
        chk("lw_rd_iord", iord, 1);
        chk("lw_rd_read", mem_read, 1);
        tick();
        tick();
        chk("lw_rd_wait_trap", trap, 0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("lw_rd_last_read", mem_read, 1);
        tick();
        chk("lw_wb_mem2reg", mem2reg, 1);
        chk("lw_wb_regw", regwrite, 1);
        chk("lw_wb_regdst", regdst, 0);
        chk("lw_wb_done", instr_done, 1);
        chk("lw_wb_trap", trap, 0);
        tick();
        // BNE taken then not taken
        opcode = 6'b000101; zero = 1'b0;
        tick();
        tick();
        chk("bne0_pcw", pc_write, 1);
        chk("bne0_pcsrc", pc_src, 2'b01);
        chk("bne0_aluop", aluop, 4'b0110);
        chk("bne0_done", instr_done, 1);
        tick();
        zero = 1'b1;
        tick();
        tick();
        chk("bne1_pcw", pc_write, 0);
        chk("bne1_done", instr_done, 1);
        tick();
        // SW abandoned by reset during MEM_WR
        opcode = 6'b101011;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("sw_wr_write", mem_write, 1);
        chk("sw_wr_iord", iord, 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("sw_rst_write", mem_write, 0);
        chk("sw_rst_iord", iord, 0);
        chk("sw_rst_done", instr_done, 0);
        mem_ready = 1'b1; opcode = 6'b000000; func = 6'b000111; mon = 1'b1;
        tick();
        chk("sw_rst_edge_done", instr_done, 0);
        chk("sw_rst_edge_read", mem_read, 0);
        #2 rst_n = 1'b1;
        #1;
        chk("sw_rel_read", mem_read, 1);
        chk("sw_rel_irw", ir_write, 1);
        // illegal func 000111 after release
        tick();
        chk("ifn_dec_bsrc", alusrc_b, 2'b11);
        tick();
        chk("ifn_x_aluop", aluop, 4'b1111);
        tick();
        chk("ifn_trap", trap, 1);
        chk("ifn_cause", trap_cause, 2'b01);
        chk("ifn_read", mem_read, 0);
        tick();
        tick();
        chk("ifn_trap_hold", trap, 1);
        chk("ifn_cause_hold", trap_cause, 2'b01);
        chk("ifn_pcw", pc_write, 0);
        rst_n = 1'b0;
        #1;
        chk("trap_rst_trap", trap, 0);
        chk("trap_rst_cause", trap_cause, 0);
        // illegal opcode 111111
        opcode = 6'b111111;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("iop_trap", trap, 1);
        chk("iop_cause", trap_cause, 2'b01);
        mon = 1'b0;
        chk("illegal_no_writes", wr_seen, 0);
        // FETCH timeout with TIMEOUT=4
        rst_n = 1'b0; mem_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("tmo_c1_read", mem_read, 1);
        tick();
        tick();
        tick();
        chk("tmo_c4_trap", trap, 0);
        chk("tmo_c4_read", mem_read, 1);
        chk("tmo_c4_irw", ir_write, 0);
        tick();
        chk("tmo_trap", trap, 1);
        chk("tmo_cause", trap_cause, 2'b10);
        chk("tmo_read", mem_read, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
